// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the control unit, mem_access_ctrl and the RAM handshake.
// The sequencer uses the slave view; the control unit / RAM side uses the master view.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              req;
    logic [5:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              trap;
    logic [1:0]        trap_cause;
    logic              mem_mfa;
    logic [5:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_mfc;

    modport slave (
        input  req, op, addr, wdata, mem_rdata, mem_mfc,
        output busy, done, rdata, trap, trap_cause,
               mem_mfa, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req, op, addr, wdata, mem_rdata, mem_mfc,
        input  busy, done, rdata, trap, trap_cause,
               mem_mfa, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: legality and alignment checks, MFA/MFC handshake with
// timeout, load sign/zero extension and sub-word store lane replication.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic              Clk,
    input logic              Clr,
    mem_access_ctrl_if.slave bus
);
    localparam logic [5:0] OP_LD   = 6'h00;
    localparam logic [5:0] OP_LDUB = 6'h01;
    localparam logic [5:0] OP_LDUH = 6'h02;
    localparam logic [5:0] OP_ST   = 6'h04;
    localparam logic [5:0] OP_STB  = 6'h05;
    localparam logic [5:0] OP_STH  = 6'h06;
    localparam logic [5:0] OP_LDSB = 6'h09;
    localparam logic [5:0] OP_LDSH = 6'h0A;

    localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_TRAP} state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    function automatic logic is_load(input logic [5:0] o);
        return (o == OP_LD) || (o == OP_LDUB) || (o == OP_LDUH) ||
               (o == OP_LDSB) || (o == OP_LDSH);
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        return is_load(o) || (o == OP_ST) || (o == OP_STB) || (o == OP_STH);
    endfunction

    // For every legal op, op[1:0] encodes the size: 00 word, 01 byte, 10 half.
    function automatic logic is_aligned(input logic [5:0] o, input logic [1:0] a);
        case (o[1:0])
            2'b00:   return a == 2'b00;
            2'b10:   return a[0] == 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [5:0] o,
                                                  input logic [DATA_W-1:0] d);
        case (o)
            OP_LDUB: return {{(DATA_W-8){1'b0}}, d[7:0]};
            OP_LDSB: return {{(DATA_W-8){d[7]}}, d[7:0]};
            OP_LDUH: return {{(DATA_W-16){1'b0}}, d[15:0]};
            OP_LDSH: return {{(DATA_W-16){d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [5:0] o,
                                                     input logic [DATA_W-1:0] w);
        case (o)
            OP_STB:  return {(DATA_W/8){w[7:0]}};
            OP_STH:  return {(DATA_W/16){w[15:0]}};
            default: return w;
        endcase
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q, done_q, trap_q, mfa_q;
    logic [1:0]        cause_q;
    logic [DATA_W-1:0] rdata_q, wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        op_q;

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trap_q  <= 1'b0;
            mfa_q   <= 1'b0;
            cause_q <= 2'b00;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            op_q    <= '0;
        end else begin
            done_q <= 1'b0;
            trap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        op_q    <= bus.op;
                        addr_q  <= bus.addr;
                        wdata_q <= replicate(bus.op, bus.wdata);
                        busy_q  <= 1'b1;
                        if (!is_legal(bus.op)) begin
                            state   <= S_TRAP;
                            trap_q  <= 1'b1;
                            cause_q <= CAUSE_ILLEGAL;
                        end else if (!is_aligned(bus.op, bus.addr[1:0])) begin
                            state   <= S_TRAP;
                            trap_q  <= 1'b1;
                            cause_q <= CAUSE_MISALIGN;
                        end else begin
                            state <= S_ACCESS;
                            cnt   <= '0;
                            mfa_q <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    // MFC is tested first so it wins over a coincident timeout.
                    if (bus.mem_mfc) begin
                        if (is_load(op_q)) rdata_q <= extend(op_q, bus.mem_rdata);
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        mfa_q  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= CAUSE_TIMEOUT;
                        mfa_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    mfa_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_mfa    = mfa_q;
    assign bus.mem_op     = op_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
endmodule
